// File: rtl/fsm3_pkg.sv
// Shared constants for the one-hot pattern FSM and its word-serialising controller.
package fsm3_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 4;

    localparam logic [3:0] FSM_A = 4'b0001;
    localparam logic [3:0] FSM_B = 4'b0010;
    localparam logic [3:0] FSM_C = 4'b0100;
    localparam logic [3:0] FSM_D = 4'b1000;

    localparam logic [CNT_W-1:0] HIT_MAX  = 4'd8;
    localparam logic [CNT_W-1:0] LAST_BIT = 4'd7;

    typedef enum logic [1:0] {
        CTRL_IDLE   = 2'd0,
        CTRL_SHIFT  = 2'd1,
        CTRL_REPORT = 2'd2
    } ctrl_state_t;

    function automatic logic is_onehot(input logic [3:0] s);
        return (s != 4'b0000) && ((s & (s - 4'd1)) == 4'b0000);
    endfunction

endpackage

// File: rtl/fsm3_onehot_next.sv
// Combinational next-state and Moore output for the A/B/C/D one-hot pattern FSM.
module fsm3_onehot_next
    import fsm3_pkg::*;
(
    input  logic       in_i,
    input  logic [3:0] state_i,
    output logic [3:0] next_state_o,
    output logic       out_o
);

    always_comb begin
        next_state_o = FSM_A;
        out_o        = state_i[3];
        case (state_i)
            FSM_A:   next_state_o = in_i ? FSM_B : FSM_A;
            FSM_B:   next_state_o = in_i ? FSM_B : FSM_C;
            FSM_C:   next_state_o = in_i ? FSM_D : FSM_A;
            FSM_D:   next_state_o = in_i ? FSM_B : FSM_C;
            // Any corrupted (non one-hot) encoding recovers to A.
            default: next_state_o = FSM_A;
        endcase
    end

endmodule

// File: rtl/fsm3_seq_ctrl.sv
// Accepts 8-bit words, feeds them LSB first through the one-hot FSM and reports
// how many times state D was entered during each word.
module fsm3_seq_ctrl
    import fsm3_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              fsm_clr,
    output logic [3:0]        fsm_state,
    output logic              fsm_out,
    output logic              out_valid,
    output logic [CNT_W-1:0]  out_count,
    output ctrl_state_t       dbg_ctrl_state
);

    // Handshake: a word transfers on a rising edge where in_valid and in_ready are
    // both high; in_ready is high only in IDLE and out_valid is never back-pressured.

    ctrl_state_t       ctrl_q, ctrl_d;
    logic [3:0]        fsm_q, fsm_d, fsm_nxt;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0]  hit_q, hit_d;
    logic              out_valid_q, out_valid_d;
    logic [CNT_W-1:0]  out_count_q, out_count_d;

    fsm3_onehot_next u_next (
        .in_i        (shreg_q[0]),
        .state_i     (fsm_q),
        .next_state_o(fsm_nxt),
        .out_o       (fsm_out)
    );

    always_comb begin
        ctrl_d      = ctrl_q;
        fsm_d       = is_onehot(fsm_q) ? fsm_q : FSM_A;
        shreg_d     = shreg_q;
        bit_cnt_d   = bit_cnt_q;
        hit_d       = hit_q;
        out_valid_d = 1'b0;
        out_count_d = out_count_q;

        case (ctrl_q)
            CTRL_IDLE: begin
                // Clear lands on the acceptance edge, so the first bit starts from A.
                if (fsm_clr) begin
                    fsm_d = FSM_A;
                end
                if (in_valid) begin
                    shreg_d   = in_data;
                    bit_cnt_d = '0;
                    hit_d     = '0;
                    ctrl_d    = CTRL_SHIFT;
                end
            end
            CTRL_SHIFT: begin
                fsm_d     = fsm_nxt;
                shreg_d   = {1'b0, shreg_q[DATA_W-1:1]};
                bit_cnt_d = bit_cnt_q + 4'd1;
                if ((fsm_nxt == FSM_D) && (hit_q < HIT_MAX)) begin
                    hit_d = hit_q + 4'd1;
                end
                if (bit_cnt_q == LAST_BIT) begin
                    ctrl_d = CTRL_REPORT;
                end
            end
            CTRL_REPORT: begin
                out_valid_d = 1'b1;
                out_count_d = hit_q;
                ctrl_d      = CTRL_IDLE;
            end
            default: begin
                ctrl_d = CTRL_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q      <= CTRL_IDLE;
            fsm_q       <= FSM_A;
            shreg_q     <= '0;
            bit_cnt_q   <= '0;
            hit_q       <= '0;
            out_valid_q <= 1'b0;
            out_count_q <= '0;
        end else begin
            ctrl_q      <= ctrl_d;
            fsm_q       <= fsm_d;
            shreg_q     <= shreg_d;
            bit_cnt_q   <= bit_cnt_d;
            hit_q       <= hit_d;
            out_valid_q <= out_valid_d;
            out_count_q <= out_count_d;
        end
    end

    assign in_ready       = (ctrl_q == CTRL_IDLE);
    assign fsm_state      = fsm_q;
    assign out_valid      = out_valid_q;
    assign out_count      = out_count_q;
    assign dbg_ctrl_state = ctrl_q;

endmodule

// File: tb/tb_fsm3_seq_ctrl.sv
// Directed and randomised checks of fsm3_seq_ctrl with a queue-based scoreboard.
module tb_fsm3_seq_ctrl;
    import fsm3_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        fsm_clr;
    logic [3:0]  fsm_state;
    logic        fsm_out;
    logic        out_valid;
    logic [3:0]  out_count;
    ctrl_state_t dbg_ctrl_state;

    fsm3_seq_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .fsm_clr       (fsm_clr),
        .fsm_state     (fsm_state),
        .fsm_out       (fsm_out),
        .out_valid     (out_valid),
        .out_count     (out_count),
        .dbg_ctrl_state(dbg_ctrl_state)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         n_assert  = 0;
    int         n_fail    = 0;
    int         n_reports = 0;
    logic [7:0] exp_q[$];
    int         acc_q[$];
    logic [3:0] model_state;
    logic [3:0] exp_trace[8];
    int         last_acc;

    function automatic logic [3:0] ref_next(input logic [3:0] s, input logic b);
        case (s)
            4'b0001: return b ? 4'b0010 : 4'b0001;
            4'b0010: return b ? 4'b0010 : 4'b0100;
            4'b0100: return b ? 4'b1000 : 4'b0001;
            4'b1000: return b ? 4'b0010 : 4'b0100;
            default: return 4'b0001;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: every out_valid pulse pops one expected word result.
    always @(negedge clk) begin
        if (!reset && out_valid) begin
            n_reports++;
            check("pending_expectation", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                logic [7:0] e;
                int         a;
                e = exp_q.pop_front();
                a = acc_q.pop_front();
                check("out_count", out_count, e[3:0]);
                check("final_state", fsm_state, e[7:4]);
                check("report_latency", cyc - a, 9);
            end
        end
    end

    // Called at a negedge; returns at the negedge after the acceptance edge with in_valid still high.
    task automatic accept(input logic [7:0] d, input logic clr);
        int         waited = 0;
        logic [3:0] st;
        logic [3:0] hits;
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check("in_ready_before_accept", in_ready, 1);
        in_valid = 1'b1;
        in_data  = d;
        fsm_clr  = clr;
        @(posedge clk);
        @(negedge clk);
        fsm_clr = 1'b0;
        st   = clr ? 4'b0001 : model_state;
        hits = 4'd0;
        for (int i = 0; i < 8; i++) begin
            st = ref_next(st, d[i]);
            exp_trace[i] = st;
            if (st == 4'b1000 && hits < 4'd8) hits++;
        end
        model_state = st;
        last_acc    = cyc;
        exp_q.push_back({st, hits});
        acc_q.push_back(cyc);
    endtask

    task automatic trace(input logic clr_during);
        fsm_clr = clr_during;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("shift_state", fsm_state, exp_trace[i]);
            check("shift_fsm_out", fsm_out, exp_trace[i][3]);
            check("in_ready_in_shift", in_ready, 0);
        end
        fsm_clr = 1'b0;
    endtask

    task automatic wait_report();
        int t = 0;
        while (exp_q.size() != 0 && t < 40) begin
            @(negedge clk);
            t++;
        end
        check("report_seen", exp_q.size(), 0);
    endtask

    initial begin
        int low;
        int first_acc;
        int r0;

        reset    = 1'b1;
        in_valid = 1'b0;
        fsm_clr  = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_fsm_state", fsm_state, 4'b0001);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_count", out_count, 0);
        check("rst_fsm_out", fsm_out, 0);
        reset       = 1'b0;
        model_state = 4'b0001;
        @(negedge clk);

        // 8'h05 from A: B,C,D,C,A,A,A,A with one D entry.
        accept(8'h05, 1'b0);
        in_valid = 1'b0;
        trace(1'b0);
        wait_report();
        repeat (3) @(negedge clk);
        check("out_count_hold", out_count, 1);

        // 8'h55 with fsm_clr held during SHIFT (ignored), then 8'h01 continuing from C.
        accept(8'h55, 1'b0);
        in_valid = 1'b0;
        trace(1'b1);
        wait_report();
        accept(8'h01, 1'b0);
        in_valid = 1'b0;
        trace(1'b0);
        wait_report();

        // Same pair with the clear on the 8'h01 acceptance cycle.
        accept(8'h55, 1'b0);
        in_valid = 1'b0;
        wait_report();
        accept(8'h01, 1'b1);
        in_valid = 1'b0;
        trace(1'b0);
        wait_report();

        // Standalone clear in IDLE after leaving the FSM in C.
        accept(8'h55, 1'b0);
        in_valid = 1'b0;
        wait_report();
        check("idle_state_before_clr", fsm_state, 4'b0100);
        fsm_clr = 1'b1;
        @(negedge clk);
        fsm_clr = 1'b0;
        model_state = 4'b0001;
        check("idle_clr_state", fsm_state, 4'b0001);

        // in_valid held high across two words.
        r0 = n_reports;
        accept(8'hFF, 1'b0);
        first_acc = last_acc;
        in_data   = 8'h05;
        low = 0;
        while (!in_ready && low < 20) begin
            low++;
            @(negedge clk);
        end
        check("in_ready_low_cycles", low, 9);
        accept(8'h05, 1'b0);
        in_valid = 1'b0;
        check("accept_spacing", last_acc - first_acc, 10);
        wait_report();
        @(negedge clk);
        check("reports_for_two_words", n_reports - r0, 2);

        // Random words with random clear on acceptance.
        for (int w = 0; w < 4; w++) begin
            accept(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
            in_valid = 1'b0;
            trace(1'b0);
            wait_report();
        end

        // Reset sampled on the 4th SHIFT edge aborts the word.
        r0 = n_reports;
        accept(8'hAA, 1'b0);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        exp_q.delete();
        acc_q.delete();
        reset       = 1'b0;
        model_state = 4'b0001;
        check("abort_fsm_state", fsm_state, 4'b0001);
        check("abort_in_ready", in_ready, 1);
        check("abort_out_valid", out_valid, 0);
        check("abort_out_count", out_count, 0);
        repeat (15) @(negedge clk);
        check("abort_no_report", n_reports - r0, 0);

        // Recovery after the aborted word.
        accept(8'h05, 1'b0);
        in_valid = 1'b0;
        trace(1'b0);
        wait_report();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
